// File: rtl/oport_arb.sv
// Output-port arbiter: round-robin grant across four input buffers, holds the grant for a
// whole packet and forwards the granted input's flits onto the link one cycle later.
module oport_arb #(
  parameter int unsigned TMO  = 16,
  parameter int unsigned PKTW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [PKTW:0]   pkt0,
  input  logic [PKTW:0]   pkt1,
  input  logic [PKTW:0]   pkt2,
  input  logic [PKTW:0]   pkt3,
  input  logic            ofull,
  output logic [3:0]      ack,
  output logic [PKTW:0]   pkto,
  output logic            busy,
  output logic            tmo
);

  localparam int unsigned CW = (TMO > 2) ? $clog2(TMO) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [1:0] TypIdle = 2'b00;
  localparam logic [1:0] TypHead = 2'b10;
  localparam logic [1:0] TypBody = 2'b01;
  localparam logic [1:0] TypTail = 2'b11;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     ack_q, ack_d;
  logic [PKTW:0]  pkto_q, pkto_d;
  logic           tmo_q, tmo_d;

  logic [PKTW:0]  flit;
  logic [1:0]     ftyp;
  logic [1:0]     win;
  logic [1:0]     idx;
  logic           found;

  always_comb begin
    unique case (sel_q)
      2'd0:    flit = pkt0;
      2'd1:    flit = pkt1;
      2'd2:    flit = pkt2;
      default: flit = pkt3;
    endcase
  end

  assign ftyp = flit[PKTW:PKTW-1];

  // First requester at or above the pointer, wrapping mod 4.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    pkto_d  = '0;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ofull && found) begin
          state_d = StBusy;
          sel_d   = win;
          ptr_d   = win + 2'd1;
          ack_d   = 4'b0001 << win;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        unique case (ftyp)
          TypHead, TypBody: begin
            pkto_d = flit;
            cnt_d  = '0;
          end
          TypTail: begin
            pkto_d  = flit;
            ack_d   = 4'b0000;
            cnt_d   = '0;
            state_d = StIdle;
          end
          default: begin
            // Bubble: a stalled input is dropped after TMO consecutive bubbles.
            if (cnt_q == CW'(TMO - 1)) begin
              ack_d   = 4'b0000;
              tmo_d   = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      ack_q   <= 4'b0000;
      pkto_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      pkto_q  <= pkto_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ack  = ack_q;
  assign pkto = pkto_q;
  assign busy = (state_q == StBusy);
  assign tmo  = tmo_q;

endmodule

// File: doc/oport_arb.md
Name: oport_arb

Overview:
- Per-output-port arbiter and flit mux sitting directly downstream of the input buffers (ib) in the 4-port switch.
- Each ib raises its request bit for this port when a head flit is waiting for it.
- The block grants one ib at a time in round-robin order and holds the grant (ack) for the whole packet.
- It forwards that ib's flits, registered, onto the output link, and releases on the tail flit or on a stall timeout.

Parameters:
- TMO, 16: consecutive bubble cycles while BUSY before the grant is force-released (must be >=2).
- Flit width comes from `PKTW in sw.vh (flit = [`PKTW:0]; bits [`PKTW:`PKTW-1] are the type: 00 idle, 10 head, 01 body, 11 tail).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  req[i]=1: ib i has a packet destined for this port.
- pkt0  in  `PKTW+1  flit output of ib 0.
- pkt1  in  `PKTW+1  flit output of ib 1.
- pkt2  in  `PKTW+1  flit output of ib 2.
- pkt3  in  `PKTW+1  flit output of ib 3.
- ofull  in  1  downstream cannot accept a new packet.
- ack  out  4  one-hot grant to ib i, held for the duration of the packet.
- pkto  out  `PKTW+1  registered output flit.
- busy  out  1  a grant is active.
- tmo  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, pkto=0, busy=0, tmo=0, rr pointer=0, bubble counter=0.
- States: IDLE, BUSY.
- IDLE, at each edge:
  - If ofull=0 and req!=0, pick the winner w = first i with req[i]=1, searching from the pointer upward mod 4.
  - Set ack=onehot(w), busy=1, go BUSY, pointer=w+1 mod 4.
  - Grant latency: req seen at edge N, ack high after edge N.
  - If ofull=1, no grant; requests are held off (no state change).
  - pkto=0 in IDLE.
- BUSY, at each edge, sample the selected flit f = pkt[w]:
  - Type 10 or 01: pkto<=f; bubble counter cleared.
  - Type 11: pkto<=f, ack<=0, busy<=0, go IDLE. The tail appears on pkto in the same cycle ack drops.
  - Type 00: pkto<=0; bubble counter +1. When the counter reaches TMO-1 and another bubble is sampled:
    - ack<=0, busy<=0, tmo<=1 for one cycle, counter<=0, go IDLE.
    - The pointer stays at w+1 (the stalled input loses priority).
- Forwarding latency: one cycle from pkt[w] to pkto.
- Flits from non-granted inputs are never forwarded.
- req and ofull are ignored while BUSY; ofull affects only new grants.
- Back-to-back packets: the earliest new grant is at the edge after the tail edge, so there is at least one cycle with ack=0 between packets. That cycle's pkto carries the tail.
- A head flit arriving mid-packet (type 10 while BUSY) is forwarded as-is. No protocol checking.
- Round-robin fairness: with all 4 requesting continuously, grants go 0,1,2,3,0,...
- tmo is 0 in every cycle except the release cycle.
- Reset mid-packet: immediate clear to the reset values. The partially forwarded packet is abandoned and pkto=0.

Test Plan:
1. Single packet, ib0: req=0001, pkt0 = 10_0000_0000, 01_0000_0000, 01_0000_0001, 11_0000_0010 -> ack=0001 one cycle after req. pkto shows the same four flits, each one cycle later. ack, busy drop at the tail edge; tmo never pulses.
2. Contention: req=1111 held, each ib sends a 4-flit packet -> grant order 0,1,2,3,0. One ack=0 cycle between grants; pkto never mixes flits from two inputs.
3. Pointer wrap: pointer=3 after granting ib2, req=1001 -> ib3 granted, then ib0. Pointer after ib3 is 0.
4. Timeout: grant ib1, send head then pkt1=0 for TMO cycles -> tmo=1 for exactly one cycle on the 16th bubble edge. ack=0000, busy=0, pkto=0; next request from ib2 is granted over ib1.
5. ofull: ofull=1 with req=0100 for 5 cycles -> ack stays 0000. Drop ofull -> ack=0100 next edge. Raising ofull mid-packet does not interrupt forwarding.
6. Reset mid-packet: assert rst between clock edges after the body flit 01_1001_0000 -> ack, pkto, busy = 0 immediately, without waiting for a clock edge. After reset release, req=0010 gets its grant starting from pointer 0.
